// File: rtl/bin2bcd_scheduler.sv
// Round-robin share of one fixed-latency Bin2BCD converter; BIN2BCD_SCHED_CACHE_EN reuses the last result on a repeated operand.
// Latency: grant to done = 1 + CONV_CYCLES cycles (1 on cache hit); backpressure: req is a held level, released after its done pulse.
module bin2bcd_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int CONV_CYCLES = 184,
    parameter int CNT_W       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  bin_in,
    output logic [NUM_REQ-1:0]     done,
    output logic [19:0]            bcd_out,
    output logic                   busy,
    output logic [15:0]            conv_bin,
    output logic                   conv_start,
    input  logic [19:0]            conv_bcd
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FLUSH,
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]      last_q, last_d;
    logic [GW-1:0]      gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [19:0]        bcd_q, bcd_d;
    logic [15:0]        bin_q, bin_d;
    logic               start_q, start_d;

    logic               any_req;
    logic [GW-1:0]      grant_idx;
    logic [15:0]        grant_bin;
    logic               cache_hit;
    logic [19:0]        hit_bcd;
    logic               capture;

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!any_req && req[(int'(last_q) + i) % NUM_REQ]) begin
                any_req   = 1'b1;
                grant_idx = GW'((int'(last_q) + i) % NUM_REQ);
            end
        end
    end

    assign grant_bin = bin_in[16*grant_idx +: 16];
    assign capture   = (state_q == S_WAIT) && (cnt_q == CNT_LAST);

`ifdef BIN2BCD_SCHED_CACHE_EN
    logic [15:0] cache_bin_q, cache_bin_d;
    logic [19:0] cache_bcd_q, cache_bcd_d;
    logic        cache_valid_q, cache_valid_d;

    always_comb begin
        cache_bin_d   = cache_bin_q;
        cache_bcd_d   = cache_bcd_q;
        cache_valid_d = cache_valid_q;
        if (capture) begin
            cache_bin_d   = bin_q;
            cache_bcd_d   = conv_bcd;
            cache_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cache_bin_q   <= '0;
            cache_bcd_q   <= '0;
            cache_valid_q <= 1'b0;
        end else begin
            cache_bin_q   <= cache_bin_d;
            cache_bcd_q   <= cache_bcd_d;
            cache_valid_q <= cache_valid_d;
        end
    end

    assign cache_hit = cache_valid_q && (grant_bin == cache_bin_q);
    assign hit_bcd   = cache_bcd_q;
`else
    assign cache_hit = 1'b0;
    assign hit_bcd   = '0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        done_d  = '0;
        bcd_d   = bcd_q;
        bin_d   = bin_q;
        start_d = 1'b0;
        case (state_q)
            // The converter has no reset; wait a full conversion so it is idle.
            S_FLUSH: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (any_req) begin
                    gnt_d  = grant_idx;
                    last_d = grant_idx;
                    if (cache_hit) begin
                        bcd_d             = hit_bcd;
                        done_d[grant_idx] = 1'b1;
                        state_d           = S_DONE;
                    end else begin
                        bin_d   = grant_bin;
                        start_d = 1'b1;
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                cnt_d   = CNT_W'(1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (capture) begin
                    bcd_d         = conv_bcd;
                    done_d[gnt_q] = 1'b1;
                    state_d       = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = S_FLUSH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_FLUSH;
            cnt_q   <= '0;
            last_q  <= GW'(NUM_REQ - 1);
            gnt_q   <= '0;
            done_q  <= '0;
            bcd_q   <= '0;
            bin_q   <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            bin_q   <= bin_d;
            start_q <= start_d;
        end
    end

    assign done       = done_q;
    assign bcd_out    = bcd_q;
    assign conv_bin   = bin_q;
    assign conv_start = start_q;
    assign busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_bin2bcd_scheduler.sv
// Directed bench for bin2bcd_scheduler with a behavioural fixed-latency converter.
module tb_bin2bcd_scheduler;
    localparam int N = 4;

    logic           clock  = 1'b0;
    logic           reset  = 1'b1;
    logic [N-1:0]   req    = '0;
    logic [16*N-1:0] bin_in = '0;
    logic [N-1:0]   done;
    logic [19:0]    bcd_out;
    logic           busy;
    logic [15:0]    conv_bin;
    logic           conv_start;
    logic [19:0]    conv_bcd;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_start = 0;

    int          ord [4];
    logic [19:0] eb  [4];

    bin2bcd_scheduler #(.NUM_REQ(N), .CONV_CYCLES(184), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .bin_in     (bin_in),
        .done       (done),
        .bcd_out    (bcd_out),
        .busy       (busy),
        .conv_bin   (conv_bin),
        .conv_start (conv_start),
        .conv_bcd   (conv_bcd)
    );

    always #5 clock = ~clock;

    // Converter model: output is junk until late in the conversion, then stable.
    logic [15:0] m_bin = '0;
    int          m_cnt = 0;
    logic        m_run = 1'b0;

    function automatic logic [19:0] to_bcd(input logic [15:0] v);
        int x;
        logic [19:0] r;
        x = int'(v);
        r = '0;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(posedge clock) begin
        if (conv_start) begin
            m_bin <= conv_bin;
            m_cnt <= 0;
            m_run <= 1'b1;
        end else if (m_run) begin
            m_cnt <= m_cnt + 1;
        end
    end

    assign conv_bcd = (m_run && m_cnt >= 178) ? to_bcd(m_bin) : 20'hABCDE;

    always @(posedge clock) begin
        if (done != '0) n_done = n_done + 1;
        if (conv_start) n_start = n_start + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_start(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            if (conv_start) begin
                n = k;
                return;
            end
        end
    endtask

    task automatic wait_done(input int budget, output int n);
        n = -1;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clock);
            if (done != '0) begin
                n = k;
                return;
            end
        end
    endtask

    // Called from an IDLE negedge; returns at the next IDLE negedge.
    task automatic do_conv(input int idx, input logic [15:0] val, input logic [19:0] exp, input string tag);
        int ns, nd;
        bin_in[16*idx +: 16] = val;
        req[idx] = 1'b1;
        wait_start(8, ns);
        check({tag, "_start_dly"}, ns, 1);
        check({tag, "_conv_bin"}, conv_bin, val);
        wait_done(300, nd);
        check({tag, "_lat"}, nd, 184);
        check({tag, "_done"}, done, 32'(1) << idx);
        check({tag, "_bcd"}, bcd_out, exp);
        req[idx] = 1'b0;
        @(negedge clock);
        check({tag, "_done_1cyc"}, done, 0);
    endtask

    task automatic rr_run(input logic [N-1:0] mask, input int cnt, input string tag);
        int nd;
        req = mask;
        for (int j = 0; j < cnt; j++) begin
            wait_done(400, nd);
            check($sformatf("%s_lat%0d", tag, j), nd, (j == 0) ? 185 : 186);
            check($sformatf("%s_done%0d", tag, j), done, 32'(1) << ord[j]);
            check($sformatf("%s_bcd%0d", tag, j), bcd_out, eb[j]);
            req[ord[j]] = 1'b0;
        end
        @(negedge clock);
    endtask

    initial begin
        int   first_start, nd, ns, snap, k_idle;
        logic b183, b184;

        // Reset values, then flush with a request already pending.
        req[0] = 1'b1;
        bin_in[15:0] = 16'd7;
        repeat (3) @(negedge clock);
        check("rst_done", done, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_start", conv_start, 0);
        check("rst_conv_bin", conv_bin, 0);
        check("rst_busy", busy, 1);
        reset = 1'b0;
        first_start = -1;
        b183 = 1'b0;
        b184 = 1'b1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            if (k == 183) b183 = busy;
            if (k == 184) b184 = busy;
            if (conv_start) begin
                first_start = k;
                break;
            end
        end
        check("flush_busy_last", b183, 1);
        check("flush_idle", b184, 0);
        check("flush_first_start", first_start, 185);
        wait_done(300, nd);
        check("flush_lat", nd, 184);
        check("flush_done", done, 4'b0001);
        check("flush_bcd", bcd_out, 20'h00007);
        req[0] = 1'b0;
        @(negedge clock);

        do_conv(1, 16'd12345, 20'h12345, "c12345");
        do_conv(0, 16'd0,     20'h00000, "c0");
        do_conv(2, 16'd65535, 20'h65535, "c65535");
        do_conv(3, 16'd9999,  20'h09999, "c9999");

        // Full contention after requester 3 won last.
        bin_in = {16'd4, 16'd3, 16'd2, 16'd1};
        ord = '{0, 1, 2, 3};
        eb  = '{20'h00001, 20'h00002, 20'h00003, 20'h00004};
        rr_run(4'b1111, 4, "rr4");

        bin_in[15:0]  = 16'd10;
        bin_in[47:32] = 16'd20;
        ord = '{0, 2, 0, 0};
        eb  = '{20'h00010, 20'h00020, 20'h0, 20'h0};
        rr_run(4'b0101, 2, "rr02");

        // Pointer now at 2: search wraps 3,0,1.
        bin_in[31:16] = 16'd31;
        bin_in[63:48] = 16'd47;
        ord = '{3, 1, 0, 0};
        eb  = '{20'h00047, 20'h00031, 20'h0, 20'h0};
        rr_run(4'b1010, 2, "rr13");

        // Dropping req after grant must not abort.
        bin_in[47:32] = 16'd42;
        req[2] = 1'b1;
        wait_start(8, ns);
        check("drop_start_dly", ns, 1);
        req[2] = 1'b0;
        wait_done(300, nd);
        check("drop_lat", nd, 184);
        check("drop_done", done, 4'b0100);
        check("drop_bcd", bcd_out, 20'h00042);
        @(negedge clock);

        // Reset in the middle of WAIT.
        bin_in[31:16] = 16'd500;
        req[1] = 1'b1;
        wait_start(8, ns);
        check("mid_start_dly", ns, 1);
        repeat (99) @(negedge clock);
        snap = n_done;
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_done", done, 0);
        check("mid_rst_bcd", bcd_out, 0);
        check("mid_rst_busy", busy, 1);
        reset = 1'b0;
        bin_in[31:16] = 16'd321;
        k_idle = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clock);
            if (!busy) begin
                k_idle = k;
                break;
            end
        end
        check("mid_flush_len", k_idle, 184);
        check("mid_no_done", n_done, snap);
        check("mid_bcd_cleared", bcd_out, 0);
        do_conv(1, 16'd321, 20'h00321, "post_rst");

`ifdef BIN2BCD_SCHED_CACHE_EN
        do_conv(0, 16'd4321, 20'h04321, "cache_fill");
        snap = n_start;
        req[0] = 1'b1;
        wait_done(8, nd);
        check("cache_lat", nd, 1);
        check("cache_done", done, 4'b0001);
        check("cache_bcd", bcd_out, 20'h04321);
        req[0] = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("cache_no_start", n_start, snap);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bin2bcd_scheduler.md
Name: bin2bcd_scheduler

Overview:
- Shares one Bin2BCD converter (16-bit binary in, 20-bit / 5-digit BCD out) between NUM_REQ requesters, e.g. display-register readout paths.
- The converter has no done flag and no reset, so this block sequences it by fixed cycle count and flushes it after reset.
- Round-robin arbitration. Sits between requesters and the single converter instance.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- CONV_CYCLES, 184, cycles from the converter sampling start=1 until it is idle again with bcd stable. Derivation: 1 idle→shift + 15×12 + 2 + 1 end state.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > CONV_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  level request per requester; held until that requester's done pulse.
- bin_in  in  16*NUM_REQ  operand of requester i at bits [16*i +: 16]; held stable while req[i]=1.
- done  out  NUM_REQ  one-hot, one-cycle pulse; bcd_out is valid for that requester.
- bcd_out  out  20  last result, registered; holds until the next done.
- busy  out  1  high whenever the state is not IDLE.
- conv_bin  out  16  to converter bin; registered.
- conv_start  out  1  to converter start; one-cycle pulse.
- conv_bcd  in  20  from converter bcd.

Behaviour:
- Reset values:
  - done=0, bcd_out=0, conv_start=0, conv_bin=0, busy=1.
  - State=FLUSH, counter=0.
  - RR pointer last=NUM_REQ-1, so requester 0 has priority first.
- FLUSH:
  - conv_start held 0; counter counts CONV_CYCLES cycles, then state goes to IDLE.
  - Guarantees the unreset converter has returned to idle. Requests are ignored during FLUSH.
- IDLE (busy=0):
  - If any req is set, grant the first set bit searching last+1, last+2, … modulo NUM_REQ.
  - On grant: conv_bin<=bin_in[grant], gnt<=grant, last<=grant, conv_start<=1, state<=START.
  - If no req, stay in IDLE.
- START:
  - conv_start is high for exactly this cycle (cycle C).
  - counter<=1, state<=WAIT.
- WAIT:
  - conv_start=0. Counter increments each cycle.
  - When counter==CONV_CYCLES-1, capture bcd_out<=conv_bcd, pulse done[gnt] next cycle, state<=DONE.
- DONE:
  - done[gnt]=1 for this single cycle, which is cycle C+CONV_CYCLES. No arbitration this cycle.
  - Next state is IDLE.
- Latency:
  - Request seen in IDLE cycle C-1, done in cycle C+184: 186 cycles inclusive.
  - Next conv_start earliest at C+186; the converter has been idle since C+184.
- Requester rules:
  - Deassert req in the cycle after its done.
  - A req still high in the IDLE cycle after done is treated as a new request.
  - Deasserting req while granted does not abort: conversion completes and done still pulses.
  - bin_in is sampled only at grant.
- Reset mid-operation (any state): abort, no done pulse, bcd_out=0, re-enter FLUSH with the full CONV_CYCLES wait.
- Widths:
  - bin is 16-bit unsigned; bcd_out is 5 packed BCD digits, max 20'h65535.
  - The counter never wraps (CNT_W check).

Optional Feature:
- Macro: BIN2BCD_SCHED_CACHE_EN.
- With the macro defined:
  - Registers cache_bin[15:0], cache_bcd[19:0], cache_valid (reset to 0). Updated at every capture in WAIT.
  - In IDLE, if the granted operand equals cache_bin and cache_valid=1: no conv_start, bcd_out<=cache_bcd, state<=DONE.
  - done therefore pulses in the cycle after the grant cycle; the RR pointer still advances.
- Without the macro: every grant runs a full conversion.

Test Plan:
- Reset flush: req[0]=1, bin=16'd7 from reset release → no conv_start for 184 cycles, then conversion → bcd_out=20'h00007.
- Single conversion: req[1], bin=16'd12345 → conv_start one cycle (C), done=4'b0010 in C+184, bcd_out=20'h12345.
- Boundaries: bin=16'd0 → 20'h00000; bin=16'd65535 → 20'h65535; bin=16'd9999 → 20'h09999.
- Round robin: req=4'b1111, distinct operands 1,2,3,4 held until each done → done order 0,1,2,3.
  - Then reassert req[0] together with req[2] → grant order 0 then 2.
- Reset mid-WAIT: reset at counter=100 → no done; busy=1 for 184 flush cycles; bcd_out=0; next request converts correctly.
- Cache (BIN2BCD_SCHED_CACHE_EN only): convert 16'd4321, then request 16'd4321 again → no conv_start, done 2 cycles after req sampled, bcd_out=20'h04321.
